uart_tx_resp_queue: RTL and testbench
=====================================

# uart_tx_resp_queue

Response byte queue between the system controller and the UART transmit path, in the REF_CLK domain. Accepts 8-bit responses (register reads) or 16-bit responses (ALU results, sent LSB first), buffers them in a small FIFO, and drains one byte at a time toward the TX data/valid synchronizers. Uses a level handshake against the synchronized UART busy flag, so the slower TX clock domain never misses a byte.

## Interface
- WIDTH, 8, byte width
- DEPTH, 8, FIFO depth in bytes; power of two, minimum 4
- TIMEOUT, 255, REF_CLK cycles TX_D_VLD may stay high without Busy rising before a retry

- CLK  in  1  REF_CLK
- RST  in  1  reset; one clock; asynchronous, active-low
- IN_DATA  in  16  response payload; [7:0] is the LSB
- IN_WIDE  in  1  1 = push both bytes (LSB then MSB); 0 = push IN_DATA[7:0] only
- IN_VALID  in  1  push request
- IN_READY  out  1  high when free slots >= 2
- Busy  in  1  UART busy, already synchronized to CLK
- TX_DATA  out  WIDTH  byte presented to the TX data synchronizer
- TX_D_VLD  out  1  level valid, held until Busy is observed high
- FIFO_COUNT  out  log2(DEPTH)+1  bytes stored
- DROP  out  1  one-cycle pulse when IN_VALID=1 and IN_READY=0
- RETRY  out  1  one-cycle pulse when a timeout retry occurs

## Operation
- Storage: DEPTH x WIDTH array; wr_ptr and rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH; count is held separately (0..DEPTH).
- Push: on IN_VALID & IN_READY.
  - Narrow push: mem[wr_ptr] <= IN_DATA[7:0]; wr_ptr += 1; count += 1.
  - Wide push: mem[wr_ptr] <= IN_DATA[7:0], mem[wr_ptr+1] <= IN_DATA[15:8]; wr_ptr += 2; count += 2.
  - A push attempted while IN_READY=0 is discarded and DROP pulses. FIFO state is unchanged.
- IN_READY = (DEPTH - count) >= 2, combinational from the registered count. It applies regardless of IN_WIDE.
- Drain FSM states: IDLE, SEND, WAIT_DONE, RETRY.
  - IDLE: when count>0 and Busy=0, register TX_DATA <= mem[rd_ptr], TX_D_VLD <= 1, clear the timer, and go to SEND.
  - SEND: TX_DATA and TX_D_VLD are held stable.
    - If Busy=1: pop (rd_ptr += 1, count -= 1), TX_D_VLD <= 0, go to WAIT_DONE.
    - Else if timer = TIMEOUT-1: TX_D_VLD <= 0, RETRY pulses, go to RETRY.
    - Otherwise the timer increments.
  - RETRY: one cycle with TX_D_VLD=0, then TX_D_VLD <= 1, clear the timer, and return to SEND. The byte is the same and is not popped.
  - WAIT_DONE: wait for Busy=0, then go to IDLE.
- Simultaneous push and pop: count <= count + n - 1 (n = 1 or 2). The write and the read never target the same slot because count>=1 in SEND.
- A push into a full FIFO is impossible; IN_READY=0 covers it.
- Reset (asynchronous, at any time, including mid-SEND): pointers, count and timer go to 0; the FSM goes to IDLE; all buffered bytes are discarded.
- Reset values: TX_D_VLD=0, TX_DATA=0, DROP=0, RETRY=0, FIFO_COUNT=0, IN_READY=1.

## Timing
- DROP and RETRY are registered pulses, exactly one cycle wide.
- Push at edge k makes FIFO_COUNT valid after edge k.
- Empty FIFO with Busy=0 and a narrow push at edge k:
  - FSM enters SEND at edge k+1.
  - TX_D_VLD=1 and TX_DATA valid from edge k+1.
- Busy seen high at edge m:
  - TX_D_VLD=0 from edge m.
  - Pop is reflected in FIFO_COUNT from edge m.
- Wide push: the LSB is transmitted first; the MSB starts SEND no earlier than the cycle after Busy is seen low.
- Minimum byte-to-byte spacing: the cycle Busy falls, plus 1 cycle in IDLE.
- Timeout: TX_D_VLD is held high for exactly TIMEOUT cycles before dropping; RETRY lasts 1 cycle.

## Test plan
- Reset, then a narrow push of 0xA5 with Busy=0 -> TX_D_VLD=1 and TX_DATA=0xA5 one cycle later. Raise Busy after 10 cycles -> TX_D_VLD=0 next edge and FIFO_COUNT=0.
- Wide push of 0x1234 -> transmitted bytes are 0x34 then 0x12. The second TX_D_VLD does not rise until Busy has fallen after the first byte.
- Busy stuck high at start, 8 narrow pushes 0x01..0x08 -> IN_READY=0 at FIFO_COUNT=7. The 8th push gives DROP=1 for one cycle and FIFO_COUNT stays 7. After Busy releases, bytes drain in order 0x01..0x07.
- Hold Busy=0 with no Busy response to a pushed byte 0x5A -> after 255 cycles TX_D_VLD=0 for 1 cycle and RETRY pulses, then TX_D_VLD=1 again with TX_DATA=0x5A and FIFO_COUNT=1.
- Push 8 bytes through a DEPTH=8 FIFO twice, with simultaneous push and pop on the same edge -> pointers wrap, the count stays consistent, and the output order is preserved.
- Assert RST low while in SEND with 3 bytes queued -> TX_D_VLD=0 immediately (asynchronous). After release, FIFO_COUNT=0 and the FSM is in IDLE with no residual transmission.

Source files
------------

// File: rtl/uart_tx_resp_queue_if.sv
// Response-queue bus: controller push side plus UART TX drain side.
// Latency: none, wires only.
// Backpressure: in_ready gates pushes; busy gates the level-valid drain.
interface uart_tx_resp_queue_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [2*WIDTH-1:0] in_data;
    logic               in_wide;
    logic               in_valid;
    logic               in_ready;
    logic               busy;
    logic [WIDTH-1:0]   tx_data;
    logic               tx_d_vld;
    logic [CW-1:0]      fifo_count;
    logic               drop;
    logic               retry;

    // Controller / UART side (drives requests and busy).
    modport master (
        output in_data, in_wide, in_valid, busy,
        input  in_ready, tx_data, tx_d_vld, fifo_count, drop, retry
    );

    // Queue side.
    modport slave (
        input  in_data, in_wide, in_valid, busy,
        output in_ready, tx_data, tx_d_vld, fifo_count, drop, retry
    );
endinterface

// File: rtl/uart_tx_resp_queue.sv
// Byte FIFO for 8/16-bit responses, drained one byte at a time to the UART TX path.
// Latency: push at edge k -> tx_d_vld/tx_data from edge k+1 when empty and idle.
// Backpressure: in_ready needs two free slots; drain holds tx_d_vld until busy, retries on timeout.
module uart_tx_resp_queue #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uart_tx_resp_queue_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_DONE, S_RETRY} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW-1:0]    wr_ptr_p1;
    logic [CW-1:0]    count;
    logic [CW-1:0]    free_slots;
    logic [TW-1:0]    timer;
    logic [WIDTH-1:0] tx_data_q;
    logic             tx_vld_q, retry_q, drop_q;

    logic             push, pop, load, timer_clr, timer_inc, vld_nxt, retry_nxt;
    logic [1:0]       push_n;
    logic             timer_expired;

    // Ready is derived from the registered count only, so it never depends on in_valid.
    assign free_slots    = CW'(DEPTH) - count;
    assign bus.in_ready  = free_slots >= CW'(2);
    assign push          = bus.in_valid & bus.in_ready;
    assign push_n        = push ? (bus.in_wide ? 2'd2 : 2'd1) : 2'd0;
    assign wr_ptr_p1     = wr_ptr + AW'(1);
    assign timer_expired = (timer == TW'(TIMEOUT - 1));

    assign bus.tx_data    = tx_data_q;
    assign bus.tx_d_vld   = tx_vld_q;
    assign bus.fifo_count = count;
    assign bus.drop       = drop_q;
    assign bus.retry      = retry_q;

    // Drain FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Drain FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (count != '0 && !bus.busy) state_nxt = S_SEND;
            S_SEND:      if (bus.busy)                 state_nxt = S_WAIT_DONE;
                         else if (timer_expired)       state_nxt = S_RETRY;
            S_RETRY:                                   state_nxt = S_SEND;
            S_WAIT_DONE: if (!bus.busy)                state_nxt = S_IDLE;
            default:                                   state_nxt = S_IDLE;
        endcase
    end

    // Drain FSM output decode: next values for the registered TX outputs and timer.
    always_comb begin
        load      = 1'b0;
        pop       = 1'b0;
        vld_nxt   = tx_vld_q;
        timer_clr = 1'b0;
        timer_inc = 1'b0;
        retry_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                if (count != '0 && !bus.busy) begin
                    load      = 1'b1;
                    vld_nxt   = 1'b1;
                    timer_clr = 1'b1;
                end
            end
            S_SEND: begin
                if (bus.busy) begin
                    pop     = 1'b1;
                    vld_nxt = 1'b0;
                end else if (timer_expired) begin
                    vld_nxt   = 1'b0;
                    retry_nxt = 1'b1;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            S_RETRY: begin
                // Same byte is re-presented; nothing is popped.
                vld_nxt   = 1'b1;
                timer_clr = 1'b1;
            end
            default: ;
        endcase
    end

    // Byte storage; contents need no reset because count qualifies every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_data[WIDTH-1:0];
            if (bus.in_wide) mem[wr_ptr_p1] <= bus.in_data[2*WIDTH-1:WIDTH];
        end
    end

    // Pointers, occupancy, timer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            timer     <= '0;
            tx_data_q <= '0;
            tx_vld_q  <= 1'b0;
            retry_q   <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(push_n);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            // Push and pop may coincide; they never hit the same slot since count>=1 in SEND.
            count <= count + CW'(push_n) - CW'(pop);
            if (timer_clr)      timer <= '0;
            else if (timer_inc) timer <= timer + TW'(1);
            if (load) tx_data_q <= mem[rd_ptr];
            tx_vld_q <= vld_nxt;
            retry_q  <= retry_nxt;
            drop_q   <= bus.in_valid & ~bus.in_ready;
        end
    end
endmodule

// File: tb/tb_uart_tx_resp_queue.sv
// Directed bench for uart_tx_resp_queue with a byte scoreboard.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: bench acts as the UART, raising busy once a byte is presented.
module tb_uart_tx_resp_queue;
    localparam int WIDTH   = 8;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 255;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   mc = 0;
    logic [7:0] sb [$];

    uart_tx_resp_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    uart_tx_resp_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Push with the bench's own acceptance model (two free slots required).
    task automatic push(input logic [15:0] d, input logic wide);
        bit acc;
        acc = (DEPTH - mc) >= 2;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_wide  = wide;
        if (acc) begin
            sb.push_back(d[7:0]);
            mc++;
            if (wide) begin
                sb.push_back(d[15:8]);
                mc++;
            end
        end
        step();
        bus.in_valid = 1'b0;
        check("push_drop", bus.drop, !acc);
        check("push_count", bus.fifo_count, mc);
    endtask

    // Act as the UART: wait for a presented byte, score it, then busy for 'hold' cycles.
    task automatic serve(input int hold);
        int n;
        logic [7:0] exp;
        n = 0;
        while (!bus.tx_d_vld && n < 50) begin
            step();
            n++;
        end
        check("serve_vld", bus.tx_d_vld, 1);
        if (sb.size() == 0) begin
            check("serve_sb_nonempty", sb.size(), 1);
        end else begin
            exp = sb.pop_front();
            check("serve_data", bus.tx_data, exp);
            mc--;
        end
        bus.busy = 1'b1;
        step();
        check("serve_vld_drop", bus.tx_d_vld, 0);
        check("serve_pop_count", bus.fifo_count, mc);
        repeat (hold) step();
        check("serve_vld_busy", bus.tx_d_vld, 0);
        bus.busy = 1'b0;
        step();
    endtask

    initial begin
        int n;
        logic [7:0] exp;
        bus.in_data  = '0;
        bus.in_wide  = 1'b0;
        bus.in_valid = 1'b0;
        bus.busy     = 1'b0;

        // Reset values
        #3;
        check("rst_vld", bus.tx_d_vld, 0);
        check("rst_data", bus.tx_data, 0);
        check("rst_drop", bus.drop, 0);
        check("rst_retry", bus.retry, 0);
        check("rst_count", bus.fifo_count, 0);
        check("rst_ready", bus.in_ready, 1);
        #10 rst_n = 1'b1;
        step();
        step();

        // Narrow push of 0xA5, busy after 10 cycles
        push(16'h00A5, 1'b0);
        check("t1_vld_early", bus.tx_d_vld, 0);
        step();
        check("t1_vld", bus.tx_d_vld, 1);
        check("t1_data", bus.tx_data, 8'hA5);
        repeat (9) step();
        check("t1_vld_hold", bus.tx_d_vld, 1);
        serve(2);
        check("t1_count", bus.fifo_count, 0);

        // Wide push: LSB first, MSB only after busy falls
        push(16'h1234, 1'b1);
        serve(4);
        check("t2_gap_vld", bus.tx_d_vld, 0);
        serve(2);

        // Fill with busy stuck high; 8th push dropped
        bus.busy = 1'b1;
        for (int i = 1; i <= 7; i++) push(16'(i), 1'b0);
        check("t3_ready", bus.in_ready, 0);
        check("t3_count7", bus.fifo_count, 7);
        push(16'h0008, 1'b0);
        step();
        check("t3_drop_pulse", bus.drop, 0);
        check("t3_count_hold", bus.fifo_count, 7);
        bus.busy = 1'b0;
        for (int i = 0; i < 7; i++) serve(1);
        check("t3_drained", bus.fifo_count, 0);

        // Timeout and retry
        push(16'h005A, 1'b0);
        step();
        check("t4_vld", bus.tx_d_vld, 1);
        n = 0;
        while (bus.tx_d_vld && n < 400) begin
            step();
            n++;
        end
        check("t4_vld_cycles", n, TIMEOUT);
        check("t4_retry", bus.retry, 1);
        step();
        check("t4_vld_again", bus.tx_d_vld, 1);
        check("t4_retry_pulse", bus.retry, 0);
        check("t4_data", bus.tx_data, 8'h5A);
        check("t4_count", bus.fifo_count, 1);
        serve(1);

        // Pointer wrap with simultaneous push and pop
        push(16'h8180, 1'b1);
        push(16'h0082, 1'b0);
        for (int i = 3; i < 16; i++) begin
            n = 0;
            while (!bus.tx_d_vld && n < 50) begin
                step();
                n++;
            end
            check("t5_vld", bus.tx_d_vld, 1);
            exp = sb.pop_front();
            check("t5_data", bus.tx_data, exp);
            bus.busy     = 1'b1;
            bus.in_valid = 1'b1;
            bus.in_wide  = 1'b0;
            bus.in_data  = 16'(8'h80 + i);
            sb.push_back(8'(8'h80 + i));
            step();
            bus.in_valid = 1'b0;
            check("t5_count", bus.fifo_count, mc);
            check("t5_drop", bus.drop, 0);
            bus.busy = 1'b0;
            step();
        end
        for (int i = 0; i < 3; i++) serve(1);
        check("t5_empty", bus.fifo_count, 0);

        // Asynchronous reset mid-SEND with 3 bytes queued
        push(16'hC3B2, 1'b1);
        push(16'h00D4, 1'b0);
        check("t6_vld", bus.tx_d_vld, 1);
        check("t6_count", bus.fifo_count, 3);
        rst_n = 1'b0;
        #1;
        check("t6_rst_vld", bus.tx_d_vld, 0);
        check("t6_rst_count", bus.fifo_count, 0);
        check("t6_rst_data", bus.tx_data, 0);
        #2 rst_n = 1'b1;
        sb.delete();
        mc = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t6_idle_vld", bus.tx_d_vld, 0);
        end
        check("t6_idle_count", bus.fifo_count, 0);
        check("t6_idle_ready", bus.in_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
